ping_pong_ctrl_n: RTL
=====================

# ping_pong_ctrl_n

Controller that drives both banks of the north-side ping-pong buffer between the linear-projection producer and the Qn x KnT matmul consumer. It accepts producer beats, writes each fill into one bank while the other bank drains, and selects the module slice stored per fill. It drains a full bank as a contiguous read burst, tagging the data with the bank that supplies it.

## Interface
- TOTAL_MODULES, 3, module slices per frame; must be ≥2.
- TOTAL_DEPTH, 16, words per bank fill, equal to COL_X; must be ≥2.
- ADDR_WIDTH, $clog2(TOTAL_DEPTH), bank address width.
- IDX_WIDTH, $clog2(TOTAL_MODULES), width of the slice index.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  producer beat valid.
- in_ready  out  1  controller can accept a beat.
- drain_en  in  1  consumer permits a drain burst to start.
- slicing_idx  out  IDX_WIDTH  slice selection for the bank being written.
- bank0_ena, bank0_wea  out  1 each  bank 0 enable and write enable.
- bank0_addra  out  ADDR_WIDTH  bank 0 address.
- bank1_ena, bank1_wea, bank1_addra  out  as for bank 0.
- out_valid  out  1  bank dout is valid this cycle.
- out_sel  out  1  bank supplying the valid dout (0/1).
- out_last  out  1  final word of the burst.
- frame_done  out  1  one-cycle pulse when the drain of slice TOTAL_MODULES-1 completes.

## Operation
- Per-bank state is EMPTY, FULL or DRAINING. The writing bank is always EMPTY, so FILLING is implied by wbank.
- Registers: wbank, rbank (1 bit each), wr_addr, rd_addr (ADDR_WIDTH), slice counter, and an out_sel pipeline.
- in_ready = (state[wbank]==EMPTY).
- Write: a beat is accepted when in_valid && in_ready. On that cycle, bank[wbank] ena=1, wea=1, addra=wr_addr, all combinational.
  - wr_addr increments on each accepted beat.
  - On the accepted beat at TOTAL_DEPTH-1: wr_addr→0, state[wbank]→FULL, wbank toggles, and slicing_idx increments, wrapping TOTAL_MODULES-1→0.
- slicing_idx is registered and is stable for the whole fill. It always reflects the fill in progress.
- Drain start: when no burst is active, state[rbank]==FULL and drain_en=1, the read of address 0 is issued that same cycle and state→DRAINING.
  - Subsequent reads issue one per cycle regardless of drain_en: ena=1, wea=0, addra=rd_addr.
- Drain end: when address TOTAL_DEPTH-1 is issued, state[rbank]→EMPTY at that edge, rbank toggles and rd_addr→0.
  - If the new rbank is FULL and drain_en=1, its address 0 issues on the next cycle, with no bubble.
- A separate drain-slice counter tracks which slice each burst carries. frame_done fires with out_last of slice TOTAL_MODULES-1.
- Any bank has exactly one of write or read active in a cycle; the controller never addresses the same bank for both.
- Both banks FULL: in_ready=0. Both EMPTY: no reads issue.
- in_valid while in_ready=0 is ignored; the producer holds data.

## Timing
- Reset values: in_ready=1, all ena/wea=0, all addra=0, slicing_idx=0, out_valid=0, out_sel=0, out_last=0, frame_done=0. Both banks EMPTY, wbank=rbank=0.
- Write latency: 0. A beat is written on the edge ending its accept cycle.
- Read latency: 1. out_valid, out_sel and out_last are registered copies of the read-issue cycle.
- Fill-to-drain: the earliest drain of a bank is the cycle after its last write (state FULL visible).
- Freed bank: it accepts writes the cycle after its last read issue.
- Reset mid-operation: all registers return to reset values immediately. Bank contents are treated as invalid and no out_valid follows.

## Test plan
Each scenario runs with TOTAL_DEPTH=4 and TOTAL_MODULES=3.
- Reset then 4 consecutive beats, drain_en=0:
  - bank0 sees addra 0,1,2,3 with wea=1 and slicing_idx=0.
  - Then in_ready stays 1 and slicing_idx becomes 1.
- Continue with 4 more beats, drain_en=0: bank1 fills at addra 0–3. in_ready drops to 0 on the following cycle.
- Raise drain_en:
  - bank0 reads addra 0–3 on consecutive cycles.
  - out_valid for 4 cycles starting one cycle later, out_sel=0, out_last on the 4th.
  - bank1 burst follows with no gap, out_sel=1.
- Streaming 12 beats with drain_en=1 throughout:
  - fills alternate banks with slicing_idx 0,1,2.
  - 3 bursts drain; frame_done pulses once with the third out_last; slicing_idx wraps to 0.
- Drain_en falls mid-burst: the burst completes all 4 reads. The next burst waits until drain_en=1.
- Assert rst_n=0 at write beat 2: all outputs are at reset values in the same cycle. After release, the next fill starts at bank0 addra 0 with slicing_idx=0.

Source files
------------

// File: rtl/ping_pong_ctrl_n_if.sv
// Bus between the ping-pong controller and its producer, consumer and the two
// buffer banks. The controller uses the slave view; the surroundings use the master view.
interface ping_pong_ctrl_n_if #(
  parameter int TOTAL_MODULES = 3,
  parameter int TOTAL_DEPTH   = 16,
  parameter int ADDR_WIDTH    = $clog2(TOTAL_DEPTH),
  parameter int IDX_WIDTH     = $clog2(TOTAL_MODULES)
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  drain_en;
  logic [IDX_WIDTH-1:0]  slicing_idx;
  logic                  bank0_ena;
  logic                  bank0_wea;
  logic [ADDR_WIDTH-1:0] bank0_addra;
  logic                  bank1_ena;
  logic                  bank1_wea;
  logic [ADDR_WIDTH-1:0] bank1_addra;
  logic                  out_valid;
  logic                  out_sel;
  logic                  out_last;
  logic                  frame_done;

  modport master (
    output in_valid, drain_en,
    input  in_ready, slicing_idx,
    input  bank0_ena, bank0_wea, bank0_addra,
    input  bank1_ena, bank1_wea, bank1_addra,
    input  out_valid, out_sel, out_last, frame_done
  );

  modport slave (
    input  in_valid, drain_en,
    output in_ready, slicing_idx,
    output bank0_ena, bank0_wea, bank0_addra,
    output bank1_ena, bank1_wea, bank1_addra,
    output out_valid, out_sel, out_last, frame_done
  );
endinterface

// File: rtl/ping_pong_ctrl_n.sv
// Ping-pong buffer controller: fills one bank from the producer while the other
// drains to the matmul consumer as a contiguous burst, tracking module slices.
module ping_pong_ctrl_n #(
  parameter int TOTAL_MODULES = 3,
  parameter int TOTAL_DEPTH   = 16,
  parameter int ADDR_WIDTH    = $clog2(TOTAL_DEPTH),
  parameter int IDX_WIDTH     = $clog2(TOTAL_MODULES)
) (
  input logic               clk,
  input logic               rst_n,
  ping_pong_ctrl_n_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FULL     = 2'd1,
    DRAINING = 2'd2
  } bank_state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_DEPTH - 1);
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(TOTAL_MODULES - 1);

  bank_state_e [1:0]     state_q;
  bank_state_e [1:0]     state_d;
  logic                  wbank;
  logic                  rbank;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [IDX_WIDTH-1:0]  fill_slice;
  logic [IDX_WIDTH-1:0]  drain_slice;
  logic                  out_valid_q;
  logic                  out_sel_q;
  logic                  out_last_q;
  logic                  frame_done_q;

  logic wr_fire;
  logic wr_last;
  logic drain_start;
  logic rd_fire;
  logic rd_last;

  // Next-state logic. The writing bank is EMPTY and the reading bank is FULL or
  // DRAINING, so a write and a read can never target the same bank.
  always_comb begin
    // NOTE: every signal gets a default before any condition so no latch is inferred.
    state_d     = state_q;
    // Gating with rst_n keeps the write strobes low while reset is held.
    wr_fire     = rst_n && bus.in_valid && (state_q[wbank] == EMPTY);
    wr_last     = wr_fire && (wr_addr == LAST_ADDR);
    drain_start = (state_q[rbank] == FULL) && bus.drain_en;
    rd_fire     = drain_start || (state_q[rbank] == DRAINING);
    rd_last     = rd_fire && (rd_addr == LAST_ADDR);

    if (wr_last)     state_d[wbank] = FULL;
    if (drain_start) state_d[rbank] = DRAINING;
    if (rd_last)     state_d[rbank] = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0]   <= EMPTY;
      state_q[1]   <= EMPTY;
      wbank        <= 1'b0;
      rbank        <= 1'b0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      fill_slice   <= '0;
      drain_slice  <= '0;
      out_valid_q  <= 1'b0;
      out_sel_q    <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;

      if (wr_fire) begin
        wr_addr <= wr_last ? '0 : wr_addr + 1'b1;
        if (wr_last) begin
          wbank      <= ~wbank;
          fill_slice <= (fill_slice == LAST_IDX) ? '0 : fill_slice + 1'b1;
        end
      end

      if (rd_fire) begin
        rd_addr <= rd_last ? '0 : rd_addr + 1'b1;
        if (rd_last) begin
          rbank       <= ~rbank;
          drain_slice <= (drain_slice == LAST_IDX) ? '0 : drain_slice + 1'b1;
        end
      end

      // Bank read latency is one cycle, so the tags trail the issue by one.
      out_valid_q  <= rd_fire;
      out_sel_q    <= rbank;
      out_last_q   <= rd_last;
      frame_done_q <= rd_last && (drain_slice == LAST_IDX);
    end
  end

  always_comb begin
    bus.bank0_ena   = 1'b0;
    bus.bank0_wea   = 1'b0;
    bus.bank0_addra = '0;
    bus.bank1_ena   = 1'b0;
    bus.bank1_wea   = 1'b0;
    bus.bank1_addra = '0;

    if (wr_fire) begin
      if (wbank == 1'b0) begin
        bus.bank0_ena   = 1'b1;
        bus.bank0_wea   = 1'b1;
        bus.bank0_addra = wr_addr;
      end else begin
        bus.bank1_ena   = 1'b1;
        bus.bank1_wea   = 1'b1;
        bus.bank1_addra = wr_addr;
      end
    end

    if (rd_fire) begin
      if (rbank == 1'b0) begin
        bus.bank0_ena   = 1'b1;
        bus.bank0_addra = rd_addr;
      end else begin
        bus.bank1_ena   = 1'b1;
        bus.bank1_addra = rd_addr;
      end
    end
  end

  assign bus.in_ready    = (state_q[wbank] == EMPTY);
  assign bus.slicing_idx = fill_slice;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sel     = out_sel_q;
  assign bus.out_last    = out_last_q;
  assign bus.frame_done  = frame_done_q;

endmodule
